velocity_ascii_to_val: RTL and testbench
========================================

Name: velocity_ascii_to_val

Overview:
- Sequential ASCII-decimal parser for numeric entry, such as a velocity setpoint typed over the UART/keypad character stream.
- Accepts one ASCII character per handshake and accumulates an optionally signed decimal number. On a terminator it presents a signed 16-bit binary value.
- It is the inverse of the LCD value-to-ASCII path: the output feeds the same signed 16-bit velocity registers that the display path renders.

Parameters:
- MAX_DIGITS, 4, maximum decimal digits accepted (range 1..4). Leading zeros count toward the limit.
- TERM_CHAR, 8'd13, primary terminator character (CR).
- ALT_TERM_CHAR, 8'd10, secondary terminator character (LF).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_char  input  8  ASCII character.
- in_valid  input  1  in_char is valid this cycle.
- in_ready  output  1  block can accept a character this cycle.
- val  output  16  signed parsed result; meaningful when out_valid=1 and err=0.
- digit_count  output  3  number of digits accepted in the presented result.
- err  output  1  presented result is a parse error; meaningful when out_valid=1.
- out_valid  output  1  result (val/err/digit_count) is presented.
- out_ready  input  1  consumer accepts the result.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: val=0, digit_count=0, err=0, out_valid=0, state=S_IDLE, internal accumulator=0, sign=0.
  - in_ready=1 from the first cycle after reset is released.
  - rst asserted mid-parse or while a result is presented discards everything; no out_valid pulse results.
- Character acceptance: a character is accepted on a rising edge where in_valid && in_ready. in_ready = (state != S_OUT), driven combinationally from state.
- Character classes:
  - digit: 8'd48..8'd57.
  - minus: 8'd45.
  - space: 8'd32.
  - terminator: TERM_CHAR or ALT_TERM_CHAR.
  - anything else is invalid.
- States and transitions:
  - S_IDLE (nothing received):
    - digit -> acc = digit, count = 1, go to S_ACC.
    - minus -> sign = 1, go to S_ACC with count = 0.
    - space or terminator -> ignored, stay in S_IDLE.
    - invalid -> go to S_ERR.
  - S_ACC:
    - digit with count < MAX_DIGITS -> acc = acc*10 + digit, count += 1. Implement as (acc<<3)+(acc<<1)+digit in one cycle; acc is 14 bits unsigned, and max 9999 fits.
    - digit with count == MAX_DIGITS -> go to S_ERR.
    - terminator with count >= 1 -> go to S_OUT with err = 0, val = sign ? -acc : acc, digit_count = count.
    - terminator with count == 0 (lone '-') -> go to S_OUT with err = 1.
    - minus, space, or invalid -> go to S_ERR.
  - S_ERR: discard every character until a terminator, then go to S_OUT with err = 1, val = 0, digit_count = 0.
  - S_OUT:
    - out_valid = 1, and val/err/digit_count are held stable.
    - on out_valid && out_ready at an edge -> go to S_IDLE, clear acc, sign, and count; out_valid = 0 next cycle.
- Latency:
  - A terminator accepted at edge N gives out_valid = 1 from the cycle after edge N.
  - If out_ready is already high, out_valid is high for exactly one cycle.
  - in_ready is low for exactly the cycles spent in S_OUT. The next character is acceptable in the cycle after the result handshake.
- Value handling:
  - "-0" yields val = 0 with err = 0.
  - The result range is -9999..9999 for MAX_DIGITS = 4.
  - val is two's complement, sign-extended to 16 bits.
- val holds its last presented value after the handshake; it changes only on entry to S_OUT or on reset.

Test Plan:
- Reset, then send "1234" + CR with out_ready=1 -> one-cycle out_valid, val=16'd1234, digit_count=4, err=0; in_ready low only during the S_OUT cycle.
- Send "-0375" + LF with out_ready=0 for 5 cycles, then 1 -> val=16'hFE89 (-375), digit_count=4, err=0; out_valid and val stable for all 6 cycles; in_ready=0 throughout.
- Send "12345" + CR -> err=1, val=0, digit_count=0. Then send "7" + CR -> val=7, err=0, showing clean recovery.
- Send " ", CR, "-", CR -> leading space and empty line ignored; the lone "-" yields err=1. Also send "1A2" + CR -> err=1; 'A' and the trailing '2' are discarded.
- Mid-parse reset: send "98", pulse rst for 1 cycle, then send "5" + CR -> no output for "98"; result is val=5, digit_count=1.
- Back-to-back: hold in_valid=1 with "9999",CR,"-9999",CR streamed, out_ready=1 -> results 16'd9999 then 16'hD8F1. No character is lost or double-accepted across the in_ready drop.

Source files
------------

// File: rtl/velocity_ascii_to_val.sv
// rtl/velocity_ascii_to_val.sv - ASCII decimal character stream to signed 16-bit value parser
//
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   in_char, in_valid          incoming ASCII character and its qualifier
//   in_ready                   low only while a result is being presented
//   val, digit_count, err      presented result (signed value, digit count, parse error)
//   out_valid, out_ready       result handshake
module velocity_ascii_to_val #(
    parameter int         MAX_DIGITS    = 4,
    parameter logic [7:0] TERM_CHAR     = 8'd13,
    parameter logic [7:0] ALT_TERM_CHAR = 8'd10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_char,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] val,
    output logic [2:0]  digit_count,
    output logic        err,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_ERR  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

    state_t      state_q, state_d;
    logic [13:0] acc_q, acc_d;
    logic        sign_q, sign_d;
    logic [2:0]  count_q, count_d;
    logic [15:0] val_q, val_d;
    logic [2:0]  dcnt_q, dcnt_d;
    logic        err_q, err_d;

    logic        accept;
    logic        is_digit, is_minus, is_space, is_term;
    logic [3:0]  digit;
    logic [13:0] acc_next;
    logic [15:0] acc_ext;
    logic [15:0] signed_val;

    // Character classification; the low nibble of '0'..'9' is the digit value.
    always_comb begin
        is_digit   = (in_char >= 8'd48) && (in_char <= 8'd57);
        is_minus   = (in_char == 8'd45);
        is_space   = (in_char == 8'd32);
        is_term    = (in_char == TERM_CHAR) || (in_char == ALT_TERM_CHAR);
        digit      = in_char[3:0];
        accept     = in_valid && (state_q != S_OUT);
        // acc*10 + digit without a multiplier; acc <= 999 here so 9999 fits in 14 bits.
        acc_next   = (acc_q << 3) + (acc_q << 1) + {10'd0, digit};
        acc_ext    = {2'b00, acc_q};
        signed_val = sign_q ? (16'd0 - acc_ext) : acc_ext;
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= 14'd0;
            sign_q  <= 1'b0;
            count_q <= 3'd0;
            val_q   <= 16'd0;
            dcnt_q  <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sign_q  <= sign_d;
            count_q <= count_d;
            val_q   <= val_d;
            dcnt_q  <= dcnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sign_d  = sign_q;
        count_d = count_q;
        val_d   = val_q;
        dcnt_d  = dcnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_digit) begin
                        acc_d   = {10'd0, digit};
                        count_d = 3'd1;
                        state_d = S_ACC;
                    end else if (is_minus) begin
                        sign_d  = 1'b1;
                        count_d = 3'd0;
                        state_d = S_ACC;
                    end else if (!(is_space || is_term)) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_ACC: begin
                if (accept) begin
                    if (is_digit) begin
                        if (count_q < MAX_CNT) begin
                            acc_d   = acc_next;
                            count_d = count_q + 3'd1;
                        end else begin
                            state_d = S_ERR;
                        end
                    end else if (is_term) begin
                        state_d = S_OUT;
                        if (count_q == 3'd0) begin
                            // Lone '-' with no digits.
                            err_d  = 1'b1;
                            val_d  = 16'd0;
                            dcnt_d = 3'd0;
                        end else begin
                            err_d  = 1'b0;
                            val_d  = signed_val;
                            dcnt_d = count_q;
                        end
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_ERR: begin
                if (accept && is_term) begin
                    state_d = S_OUT;
                    err_d   = 1'b1;
                    val_d   = 16'd0;
                    dcnt_d  = 3'd0;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    acc_d   = 14'd0;
                    sign_d  = 1'b0;
                    count_d = 3'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        in_ready    = (state_q != S_OUT);
        out_valid   = (state_q == S_OUT);
        val         = val_q;
        digit_count = dcnt_q;
        err         = err_q;
    end

endmodule

// File: tb/tb_velocity_ascii_to_val.sv
// tb/tb_velocity_ascii_to_val.sv - self-checking bench for velocity_ascii_to_val
module tb_velocity_ascii_to_val;

    localparam int MAXD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_char;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] val;
    logic [2:0]  digit_count;
    logic        err;
    logic        out_valid;
    logic        out_ready;

    always #5 clk = ~clk;

    velocity_ascii_to_val #(
        .MAX_DIGITS(MAXD),
        .TERM_CHAR(8'd13),
        .ALT_TERM_CHAR(8'd10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_char(in_char),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .val(val),
        .digit_count(digit_count),
        .err(err),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    typedef struct {
        bit         e;
        bit         zero;
        logic [15:0] v;
        logic [2:0]  c;
    } res_t;

    typedef struct {
        string       body;
        logic [7:0]  term;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    res_t exp_q[$];
    bit   rand_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference: one line of text (between terminators) -> result, by string rules.
    function automatic void model(input string s, output bit has, output res_t r);
        int i = 0;
        int nd;
        int v = 0;
        bit neg = 1'b0;
        bit ok = 1'b1;
        r.e = 1'b0; r.zero = 1'b0; r.v = 16'd0; r.c = 3'd0;
        while (i < s.len() && s[i] == 8'd32) i++;
        has = (i < s.len());
        if (!has) return;
        if (s[i] == 8'd45) begin neg = 1'b1; i++; end
        nd = s.len() - i;
        for (int k = i; k < s.len(); k++) begin
            if (s[k] < 8'd48 || s[k] > 8'd57) ok = 1'b0;
            else v = v * 10 + (int'(s[k]) - 48);
        end
        if (!ok || nd > MAXD) begin
            r.e = 1'b1; r.zero = 1'b1;
        end else if (nd == 0) begin
            r.e = 1'b1;
        end else begin
            r.v = 16'(neg ? -v : v);
            r.c = 3'(nd);
        end
    endfunction

    // Result monitor: scoreboard compare, hold-stability and in_ready/out_valid relation.
    logic        hold_vld = 1'b0;
    logic [15:0] hold_val;
    logic        hold_err;
    logic [2:0]  hold_dc;
    always begin
        @(negedge clk);
        #3;
        if (rst) begin
            hold_vld = 1'b0;
        end else begin
            check("in_ready_vs_out_valid", 32'(in_ready), 32'(!out_valid));
            if (hold_vld) begin
                check("hold_out_valid", 32'(out_valid), 32'd1);
                check("hold_val", 32'(val), 32'(hold_val));
                check("hold_err", 32'(err), 32'(hold_err));
                check("hold_digit_count", 32'(digit_count), 32'(hold_dc));
            end
            hold_vld = out_valid && !out_ready;
            hold_val = val; hold_err = err; hold_dc = digit_count;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_result: got val %0h err %0b, expected none", val, err);
                end else begin
                    res_t r;
                    r = exp_q.pop_front();
                    check("res_err", 32'(err), 32'(r.e));
                    if (!r.e || r.zero) begin
                        check("res_val", 32'(val), 32'(r.v));
                        check("res_digit_count", 32'(digit_count), 32'(r.c));
                    end
                end
            end
        end
    end

    always @(negedge clk) if (rand_rdy) out_ready = 1'($urandom_range(0, 1));

    task automatic send_char(input logic [7:0] c);
        int guard = 0;
        @(negedge clk);
        in_char  = c;
        in_valid = 1'b1;
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            n_cmp++; n_bad++;
            $display("FAIL in_ready_timeout: got in_ready 0, expected 1 within 300 cycles");
        end
        @(posedge clk);
    endtask

    task automatic send_line(input string body, input logic [7:0] term);
        bit   has;
        res_t r;
        model(body, has, r);
        if (has) exp_q.push_back(r);
        for (int k = 0; k < body.len(); k++) send_char(body[k]);
        send_char(term);
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || out_valid) && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: got %0d results pending, expected 0", exp_q.size());
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        #900000;
        $display("FAIL global_timeout: got no finish, expected finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{"0", 8'd13};
        vecs[1] = '{"-1", 8'd10};
        vecs[2] = '{"  42", 8'd13};
        vecs[3] = '{"-9999", 8'd13};
        vecs[4] = '{"0001", 8'd10};
        vecs[5] = '{"-0", 8'd13};
        vecs[6] = '{"1 2", 8'd13};
        vecs[7] = '{"--5", 8'd10};

        rst = 1'b1; in_valid = 1'b0; in_char = 8'd0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_val", 32'(val), 32'd0);
        check("reset_digit_count", 32'(digit_count), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk); #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // "1234" CR with out_ready high: single-cycle result.
        send_line("1234", 8'd13);
        @(negedge clk); in_valid = 1'b0; #1;
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_in_ready", 32'(in_ready), 32'd0);
        check("t1_val", 32'(val), 32'd1234);
        check("t1_digit_count", 32'(digit_count), 32'd4);
        check("t1_err", 32'(err), 32'd0);
        @(negedge clk); #1;
        check("t1_out_valid_drop", 32'(out_valid), 32'd0);
        check("t1_in_ready_back", 32'(in_ready), 32'd1);
        drain();

        // "-0375" LF held for 5 cycles by out_ready low.
        out_ready = 1'b0;
        send_line("-0375", 8'd10);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); in_valid = 1'b0; #1;
            check("t2_out_valid", 32'(out_valid), 32'd1);
            check("t2_val", 32'(val), 32'hFE89);
            check("t2_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk); out_ready = 1'b1; #1;
        check("t2_out_valid_last", 32'(out_valid), 32'd1);
        check("t2_digit_count", 32'(digit_count), 32'd4);
        @(negedge clk); #1;
        check("t2_out_valid_drop", 32'(out_valid), 32'd0);
        check("t2_val_held", 32'(val), 32'hFE89);
        drain();

        // Too many digits, then clean recovery.
        send_line("12345", 8'd13);
        @(negedge clk); in_valid = 1'b0; #1;
        check("t3_err", 32'(err), 32'd1);
        check("t3_val", 32'(val), 32'd0);
        send_line("7", 8'd13);
        drain();

        // Ignored space/empty line, lone '-', embedded invalid character.
        send_line(" ", 8'd13);
        send_line("-", 8'd13);
        send_line("1A2", 8'd13);
        drain();

        // Mid-parse reset discards "98".
        send_char(8'd57);
        send_char(8'd56);
        @(negedge clk); in_valid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        send_line("5", 8'd13);
        @(negedge clk); in_valid = 1'b0; #1;
        check("t5_val", 32'(val), 32'd5);
        check("t5_digit_count", 32'(digit_count), 32'd1);
        drain();

        // Back-to-back with in_valid held across the in_ready drop.
        send_line("9999", 8'd13);
        send_line("-9999", 8'd13);
        drain();
        check("t6_last_val", 32'(val), 32'hD8F1);

        // Table vectors.
        for (int i = 0; i < 8; i++) send_line(vecs[i].body, vecs[i].term);
        drain();

        // Randomized lines with random consumer backpressure.
        rand_rdy = 1'b1;
        for (int n = 0; n < 150; n++) begin
            string s = "";
            int kind = $urandom_range(0, 3);
            int nd;
            logic [7:0] term = ($urandom_range(0, 1) != 0) ? 8'd13 : 8'd10;
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) s = {s, " "};
            if (kind == 3) begin
                if ($urandom_range(0, 1) != 0) s = {s, "-"};
            end else begin
                if ($urandom_range(0, 1) != 0) s = {s, "-"};
                nd = (kind == 1) ? int'($urandom_range(5, 6)) : int'($urandom_range(1, MAXD));
                for (int k = 0; k < nd; k++) s = $sformatf("%s%c", s, 8'(48 + $urandom_range(0, 9)));
                if (kind == 2) begin
                    logic [7:0] g;
                    string t;
                    int pos = $urandom_range(0, s.len() - 1);
                    do g = 8'($urandom_range(1, 127)); while (g == 8'd10 || g == 8'd13);
                    t = "";
                    for (int k = 0; k < s.len(); k++)
                        t = $sformatf("%s%c", t, (k == pos) ? g : s[k]);
                    s = t;
                end
            end
            send_line(s, term);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
        end
        rand_rdy = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
